lsu_axi_bridge: RTL and testbench
=================================

Name: lsu_axi_bridge

Overview:
Downstream neighbour of the load/store unit. Converts the LSU's single-outstanding io_* memory request interface (level request, one-cycle response pulse, byte write mask) into single-beat AXI4 master transactions on the SoC interconnect. Captures each request at acceptance so that the LSU may change io_addr/io_wmask afterwards. Reports bus errors through a sticky flag.

Parameters:
AXI_ID, 4'h0, constant driven on m_arid and m_awid.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
io_reqValid  in  1  LSU request (level; may stay high one extra cycle after acceptance)
io_respValid  out  1  one-cycle completion pulse
io_addr  in  32  byte address
io_size  in  2  0=byte, 1=half, 2=word, 3=word
io_wen  in  1  1=write, 0=read
io_wdata  in  32  lane-aligned write data
io_wmask  in  4  byte strobes
io_rdata  out  32  read data, valid when io_respValid=1, held until next read completes
bus_err  out  1  sticky error flag
bus_err_addr  out  32  captured address of first error
bus_err_clr  in  1  clears bus_err
m_arvalid/m_arready  out/in  1  AR handshake
m_araddr  out  32
m_arsize  out  3  {1'b0, io_size}, with 3 mapped to 3'b010
m_arid  out  4
m_rvalid/m_rready  in/out  1
m_rdata  in  32
m_rresp  in  2
m_awvalid/m_awready  out/in  1
m_awaddr  out  32
m_awsize  out  3  same mapping as m_arsize
m_awid  out  4
m_wvalid/m_wready  out/in  1
m_wdata  out  32
m_wstrb  out  4
m_wlast  out  1  tied 1
m_bvalid/m_bready  in/out  1
m_bresp  in  2
m_arlen/m_awlen (8, tied 0) and m_arburst/m_awburst (2, tied INCR=2'b01) are outputs.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All m_*valid, m_rready, m_bready, io_respValid and bus_err are 0. io_rdata, bus_err_addr and the captured request registers are 0. Reset mid-transaction abandons it without completion. The interconnect is reset in the same domain.
- Acceptance: a request is accepted when io_reqValid=1 and either state=IDLE or io_respValid=1 in that cycle (back-to-back, as needed for the misaligned second part).
  - At acceptance, addr, size, wen, wdata and wmask are registered.
  - io_reqValid in the cycle after acceptance is ignored.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- Read path, IDLE/DONE to RD_ADDR:
  - m_arvalid=1 with the captured fields, held stable until m_arready.
  - On the handshake, go to RD_DATA with m_rready=1.
  - On m_rvalid, register m_rdata into io_rdata, check m_rresp, go to DONE.
- Write path, to WR_REQ:
  - m_awvalid and m_wvalid both rise in the same cycle. Each drops independently after its own handshake, tracked by aw_done/w_done flags.
  - When both flags are set, go to WR_RESP with m_bready=1.
  - On m_bvalid, check m_bresp and go to DONE.
- DONE: io_respValid=1 for exactly one cycle. The next state is IDLE, or RD_ADDR/WR_REQ if a request is accepted in that cycle.
- Latency: with zero-wait-state slaves (ready/valid high immediately), io_respValid is asserted 3 cycles after acceptance. The minimum latency is 3 cycles, so io_respValid never appears in the cycle after acceptance.
- Errors:
  - m_rresp or m_bresp != 2'b00 sets bus_err. If bus_err was 0, the captured address is written to bus_err_addr.
  - The transaction still completes normally. io_rdata takes m_rdata regardless of the response.
  - bus_err_clr=1 clears bus_err in the next cycle. An error in that same cycle wins, so bus_err stays set and bus_err_addr is updated.
- Writes do not modify io_rdata.
- Only one transaction is outstanding at a time. No address/data reordering.
- AXI signals are driven from registers; there is no combinational path from m_*ready to m_*valid.

Test Plan:
- Read word 0x8000_0004, slave zero-wait, rdata=0xDEADBEEF, rresp=0 -> m_araddr=0x80000004, m_arsize=3'b010; io_respValid pulses 3 cycles after acceptance; io_rdata=0xDEADBEEF.
- Write byte, addr 0x8000_0003, wdata 0x11000000, wmask 4'b1000; awready delayed 2 cycles, wready immediate -> m_wvalid drops after 1 cycle, m_awvalid after 3; m_wstrb=4'b1000; one io_respValid after the B handshake.
- Misaligned pair: first read completes; io_reqValid=1 in the DONE cycle with addr 0x8000_0008 -> new AR issued the next cycle with no IDLE cycle. Stale io_reqValid in the following cycle creates no third transaction.
- Error: bresp=2'b10 on write to 0x1000_0000 -> bus_err=1, bus_err_addr=0x10000000. A second error at 0x2000_0000 leaves bus_err_addr unchanged. bus_err_clr clears the flag.
- Reset asserted while in RD_DATA with rvalid pending -> all valids and io_respValid go to 0 immediately. After release, state=IDLE and the next read proceeds normally.
- Random ready/valid backpressure, 1000 mixed reads and writes against a reference memory -> every io_respValid matches the model; exactly one response per accepted request.

Source files
------------

// File: rtl/lsu_axi_bridge.sv
// lsu_axi_bridge: turns the LSU's single-outstanding io_* requests into single-beat AXI4 transactions.
// Rev 1.0 - initial release.
`default_nettype none

module lsu_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_reqValid,
  output logic        io_respValid,
  input  logic [31:0] io_addr,
  input  logic [1:0]  io_size,
  input  logic        io_wen,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_wmask,
  output logic [31:0] io_rdata,
  output logic        bus_err,
  output logic [31:0] bus_err_addr,
  input  logic        bus_err_clr,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arsize,
  output logic [3:0]  m_arid,
  output logic [7:0]  m_arlen,
  output logic [1:0]  m_arburst,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_awaddr,
  output logic [2:0]  m_awsize,
  output logic [3:0]  m_awid,
  output logic [7:0]  m_awlen,
  output logic [1:0]  m_awburst,
  output logic        m_wvalid,
  input  logic        m_wready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wlast,
  input  logic        m_bvalid,
  output logic        m_bready,
  input  logic [1:0]  m_bresp
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic [31:0] r_wdata;
  logic [3:0]  r_wmask;
  logic        r_aw_done;
  logic        r_w_done;
  logic [31:0] r_rdata;
  logic        r_bus_err;
  logic [31:0] r_bus_err_addr;

  logic        w_accept;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_err;
  logic [2:0]  w_axsize;

  assign w_accept = io_reqValid && ((r_state == IDLE) || (r_state == DONE));
  assign w_aw_hs  = m_awvalid && m_awready;
  assign w_w_hs   = m_wvalid && m_wready;
  assign w_err    = ((r_state == RD_DATA) && m_rvalid && (m_rresp != 2'b00)) ||
                    ((r_state == WR_RESP) && m_bvalid && (m_bresp != 2'b00));
  // AXI has no 3-byte size; the LSU's size 3 means a full word
  assign w_axsize = (r_size == 2'd3) ? 3'b010 : {1'b0, r_size};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) w_next = io_wen ? WR_REQ : RD_ADDR;
        else          w_next = IDLE;
      end
      RD_ADDR: if (m_arready) w_next = RD_DATA;
      RD_DATA: if (m_rvalid)  w_next = DONE;
      WR_REQ:  if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = WR_RESP;
      WR_RESP: if (m_bvalid)  w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr         <= '0;
      r_size         <= '0;
      r_wdata        <= '0;
      r_wmask        <= '0;
      r_aw_done      <= 1'b0;
      r_w_done       <= 1'b0;
      r_rdata        <= '0;
      r_bus_err      <= 1'b0;
      r_bus_err_addr <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= io_addr;
        r_size  <= io_size;
        r_wdata <= io_wdata;
        r_wmask <= io_wmask;
      end
      if (r_state != WR_REQ) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end
      if ((r_state == RD_DATA) && m_rvalid) r_rdata <= m_rdata;
      // a new error outranks a clear issued in the same cycle
      if (w_err) begin
        r_bus_err <= 1'b1;
        if (!r_bus_err || bus_err_clr) r_bus_err_addr <= r_addr;
      end else if (bus_err_clr) begin
        r_bus_err <= 1'b0;
      end
    end
  end

  assign io_respValid = (r_state == DONE);
  assign io_rdata     = r_rdata;
  assign bus_err      = r_bus_err;
  assign bus_err_addr = r_bus_err_addr;

  assign m_arvalid = (r_state == RD_ADDR);
  assign m_araddr  = r_addr;
  assign m_arsize  = w_axsize;
  assign m_arid    = AXI_ID;
  assign m_arlen   = 8'd0;
  assign m_arburst = 2'b01;
  assign m_rready  = (r_state == RD_DATA);

  assign m_awvalid = (r_state == WR_REQ) && !r_aw_done;
  assign m_awaddr  = r_addr;
  assign m_awsize  = w_axsize;
  assign m_awid    = AXI_ID;
  assign m_awlen   = 8'd0;
  assign m_awburst = 2'b01;
  assign m_wvalid  = (r_state == WR_REQ) && !r_w_done;
  assign m_wdata   = r_wdata;
  assign m_wstrb   = r_wmask;
  assign m_wlast   = 1'b1;
  assign m_bready  = (r_state == WR_RESP);

endmodule

`default_nettype wire

// File: tb/tb_lsu_axi_bridge.sv
// Scoreboarded bench for lsu_axi_bridge: LSU driver, AXI slave with backpressure, reference memory.
`default_nettype none

module tb_lsu_axi_bridge;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_reqValid = 1'b0, io_wen = 1'b0, bus_err_clr = 1'b0;
  logic [31:0] io_addr = '0, io_wdata = '0;
  logic [1:0]  io_size = '0;
  logic [3:0]  io_wmask = '0;
  logic        io_respValid, bus_err;
  logic [31:0] io_rdata, bus_err_addr;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic [2:0]  m_arsize, m_awsize;
  logic [3:0]  m_arid, m_awid, m_wstrb;
  logic [7:0]  m_arlen, m_awlen;
  logic [1:0]  m_arburst, m_awburst, m_rresp, m_bresp;

  lsu_axi_bridge #(.AXI_ID(4'h0)) dut (
    .clock(clock), .reset(reset),
    .io_reqValid(io_reqValid), .io_respValid(io_respValid), .io_addr(io_addr),
    .io_size(io_size), .io_wen(io_wen), .io_wdata(io_wdata), .io_wmask(io_wmask),
    .io_rdata(io_rdata), .bus_err(bus_err), .bus_err_addr(bus_err_addr), .bus_err_clr(bus_err_clr),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arsize(m_arsize),
    .m_arid(m_arid), .m_arlen(m_arlen), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awsize(m_awsize),
    .m_awid(m_awid), .m_awlen(m_awlen), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic [31:0] rdata; int acc; bit exact; } exp_t;
  typedef struct { bit wen; logic [31:0] addr; logic [2:0] size; logic [31:0] wdata; logic [3:0] strb; } bus_t;
  exp_t sb[$];
  bus_t bq[$];

  logic [31:0] rmem [int unsigned];
  logic [31:0] smem [int unsigned];
  logic [31:0] last_rdata = '0;

  bit   cfg_fixed = 1'b1;
  int   cfg_ar = 0, cfg_r = 0, cfg_aw = 0, cfg_w = 0, cfg_b = 0;
  logic [1:0] cfg_rresp = 2'b00, cfg_bresp = 2'b00;
  int   last_aw_hi = 0, last_w_hi = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int unsigned w);
    logic [15:0] lo;
    lo = w[15:0];
    return {lo ^ 16'h5A5A, lo};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic int pick(input int fixed);
    return cfg_fixed ? fixed : int'($urandom_range(0, 3));
  endfunction

  // AXI slave: one transaction at a time, inputs changed on the falling edge
  initial begin
    bus_t e;
    int unsigned w;
    int d, da, dw, n;
    bit ag, wg;
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = '0;
    forever begin
      @(negedge clock);
      if (reset && m_arvalid) begin
        if (bq.size() == 0) chk("bus_unexpected_ar", 32'd1, 32'd0);
        else begin
          e = bq.pop_front();
          chk("ar_is_read", {31'd0, e.wen}, 32'd0);
          chk("araddr", m_araddr, e.addr);
          chk("arsize", {29'd0, m_arsize}, {29'd0, e.size});
          chk("ar_const", {m_arid, m_arlen, m_arburst}, {4'h0, 8'd0, 2'b01});
        end
        w = m_araddr[31:2];
        d = pick(cfg_ar);
        repeat (d) @(negedge clock);
        m_arready = 1;
        @(negedge clock);
        m_arready = 0;
        d = pick(cfg_r);
        repeat (d) @(negedge clock);
        m_rvalid = 1;
        m_rdata  = smem.exists(w) ? smem[w] : init_word(w);
        m_rresp  = cfg_rresp;
        @(negedge clock);
        m_rvalid = 0; m_rresp = '0;
      end else if (reset && (m_awvalid || m_wvalid)) begin
        chk("aw_w_together", {30'd0, m_awvalid, m_wvalid}, 32'd3);
        if (bq.size() == 0) chk("bus_unexpected_aw", 32'd1, 32'd0);
        else begin
          e = bq.pop_front();
          chk("aw_is_write", {31'd0, e.wen}, 32'd1);
          chk("awaddr", m_awaddr, e.addr);
          chk("awsize", {29'd0, m_awsize}, {29'd0, e.size});
          chk("wdata", m_wdata, e.wdata);
          chk("wstrb", {28'd0, m_wstrb}, {28'd0, e.strb});
          chk("aw_const", {m_awid, m_awlen, m_awburst, m_wlast}, {4'h0, 8'd0, 2'b01, 1'b1});
        end
        w = m_awaddr[31:2];
        smem[w] = merge(smem.exists(w) ? smem[w] : init_word(w), m_wdata, m_wstrb);
        da = pick(cfg_aw); dw = pick(cfg_w);
        ag = 0; wg = 0; n = 0; last_aw_hi = 0; last_w_hi = 0;
        while (!(ag && wg)) begin
          if (m_awvalid) last_aw_hi++;
          if (m_wvalid)  last_w_hi++;
          m_awready = !ag && (n >= da);
          m_wready  = !wg && (n >= dw);
          @(negedge clock);
          if (m_awready) ag = 1;
          if (m_wready)  wg = 1;
          n++;
        end
        m_awready = 0; m_wready = 0;
        d = pick(cfg_b);
        repeat (d) @(negedge clock);
        m_bvalid = 1; m_bresp = cfg_bresp;
        @(negedge clock);
        m_bvalid = 0; m_bresp = '0;
      end
    end
  end

  // response monitor
  always @(negedge clock) begin
    exp_t x;
    if (reset && io_respValid) begin
      if (sb.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
      else begin
        x = sb.pop_front();
        chk("io_rdata", io_rdata, x.rdata);
        if (x.exact) chk("latency", cyc - x.acc, 32'd3);
        else         chk("latency_min", {31'd0, (cyc - x.acc) >= 3}, 32'd1);
      end
    end
  end

  // call at a falling edge; returns at the falling edge after acceptance (plus one if stale)
  task automatic issue(input bit wen, input logic [31:0] addr, input logic [1:0] size,
                       input logic [31:0] wdata, input logic [3:0] wmask, input bit exact, input bit stale);
    int unsigned w;
    exp_t x;
    bus_t b;
    w = addr[31:2];
    if (wen) rmem[w] = merge(rmem.exists(w) ? rmem[w] : init_word(w), wdata, wmask);
    else     last_rdata = rmem.exists(w) ? rmem[w] : init_word(w);
    x.rdata = last_rdata; x.acc = cyc; x.exact = exact;
    b.wen = wen; b.addr = addr; b.size = (size == 2'd3) ? 3'b010 : {1'b0, size};
    b.wdata = wdata; b.strb = wmask;
    sb.push_back(x);
    bq.push_back(b);
    io_reqValid = 1; io_wen = wen; io_addr = addr; io_size = size; io_wdata = wdata; io_wmask = wmask;
    @(negedge clock);
    io_addr = $urandom; io_wmask = 4'($urandom); io_wdata = $urandom; io_wen = 1'($urandom);
    if (stale) @(negedge clock);
    io_reqValid = 0;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (!io_respValid && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!io_respValid) begin
      vectors++; miscompares++;
      $display("FAIL resp_timeout: no io_respValid within %0d cycles", n);
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] d);
    rmem[addr[31:2]] = d;
    smem[addr[31:2]] = d;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    chk("reset_outputs", {25'd0, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, io_respValid, bus_err}, 32'd0);
    chk("reset_rdata", io_rdata, 32'd0);
    chk("reset_err_addr", bus_err_addr, 32'd0);
    reset = 1;
    @(negedge clock);

    preload(32'h8000_0004, 32'hDEADBEEF);
    issue(0, 32'h8000_0004, 2'd2, 0, 0, 1, 0);
    wait_resp();
    chk("read_rdata_direct", io_rdata, 32'hDEADBEEF);

    cfg_aw = 2;
    repeat (2) @(negedge clock);
    issue(1, 32'h8000_0003, 2'd0, 32'h1100_0000, 4'b1000, 0, 0);
    wait_resp();
    cfg_aw = 0;
    chk("awvalid_cycles", last_aw_hi, 32'd3);
    chk("wvalid_cycles", last_w_hi, 32'd1);

    // misaligned pair: second request in the DONE cycle, stale level one cycle later
    @(negedge clock);
    issue(0, 32'h8000_0004, 2'd2, 0, 0, 1, 0);
    wait_resp();
    issue(0, 32'h8000_0008, 2'd2, 0, 0, 1, 1);
    wait_resp();
    repeat (5) @(negedge clock);
    chk("no_third_txn", {31'd0, m_arvalid || m_awvalid}, 32'd0);
    chk("sb_empty_pair", sb.size(), 32'd0);

    cfg_bresp = 2'b10;
    issue(1, 32'h1000_0000, 2'd2, 32'h1234_5678, 4'hF, 1, 0);
    wait_resp();
    cfg_bresp = 2'b00;
    chk("bus_err_set", {31'd0, bus_err}, 32'd1);
    chk("bus_err_addr_first", bus_err_addr, 32'h1000_0000);
    @(negedge clock);
    cfg_rresp = 2'b10;
    issue(0, 32'h2000_0000, 2'd2, 0, 0, 1, 0);
    wait_resp();
    cfg_rresp = 2'b00;
    chk("bus_err_held", {31'd0, bus_err}, 32'd1);
    chk("bus_err_addr_kept", bus_err_addr, 32'h1000_0000);
    @(negedge clock);
    cfg_bresp = 2'b01;
    issue(1, 32'h3000_0000, 2'd1, 32'h0000_ABCD, 4'b0011, 1, 0);
    @(negedge clock);
    bus_err_clr = 1;
    wait_resp();
    bus_err_clr = 0;
    cfg_bresp = 2'b00;
    chk("err_beats_clr", {31'd0, bus_err}, 32'd1);
    chk("err_addr_on_clr", bus_err_addr, 32'h3000_0000);
    @(negedge clock);
    bus_err_clr = 1;
    @(negedge clock);
    bus_err_clr = 0;
    chk("bus_err_cleared", {31'd0, bus_err}, 32'd0);

    // reset while the read data is pending
    cfg_r = 8;
    issue(0, 32'h8000_0010, 2'd2, 0, 0, 0, 0);
    for (int i = 0; i < 20 && !m_rready; i++) @(negedge clock);
    chk("reached_rd_data", {31'd0, m_rready}, 32'd1);
    #2 reset = 0;
    #1;
    chk("async_reset_outputs", {25'd0, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, io_respValid, bus_err}, 32'd0);
    chk("async_reset_rdata", io_rdata, 32'd0);
    sb.delete();
    last_rdata = '0;
    repeat (15) @(negedge clock);
    reset = 1;
    cfg_r = 0;
    @(negedge clock);
    preload(32'h8000_0014, 32'hCAFE_F00D);
    issue(0, 32'h8000_0014, 2'd3, 0, 0, 1, 0);
    wait_resp();

    cfg_fixed = 0;
    for (int t = 0; t < 1000 && miscompares <= 20; t++) begin
      logic [31:0] a;
      repeat ($urandom_range(0, 2)) @(negedge clock);
      a = 32'h8000_0000 | ($urandom_range(0, 63) << 2) | 32'($urandom_range(0, 3));
      issue(1'($urandom), a, 2'($urandom), $urandom, 4'($urandom), 0, 1'($urandom));
      wait_resp();
    end
    repeat (10) @(negedge clock);
    chk("sb_empty_end", sb.size(), 32'd0);
    chk("bq_empty_end", bq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
